johnson_updown_counter_param: RTL and testbench

Parametrised Johnson (twisted-ring) up/down counter: the generalised successor to the fixed 4-bit Johnson up/down counter in the counter library. It adds configurable width and reset phase, plus a synchronous phase load. It also provides a registered binary phase index, a wrap pulse, and detection and self-correction of illegal codes. It is intended as a glitch-free sequencer and phase generator feeding clock-enable and multiphase-control logic.

---
 rtl/johnson_updown_counter_param.sv | 101 ++++++++++
 tb/tb_johnson_updown_counter_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_updown_counter_param.sv
// Parametrised Johnson (twisted-ring) up/down counter with registered phase index,
// wrap pulse, synchronous phase load and self-correction of illegal codes.
module johnson_updown_counter_param #(
  parameter int WIDTH       = 4,
  parameter int RESET_PHASE = 0,
  localparam int PW         = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [PW-1:0]    load_phase,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             load_err,
  output logic             state_err
);

  localparam int            NPH        = 2 * WIDTH;
  localparam logic [PW-1:0] LAST_PHASE = PW'(NPH - 1);
  localparam logic [PW-1:0] RST_PHASE  = PW'(RESET_PHASE);
  localparam logic [PW-1:0] ONE_PHASE  = PW'(1);

  // Phase k: low k bits set up to WIDTH, then low (k-WIDTH) bits cleared.
  function automatic logic [WIDTH-1:0] code_of(input logic [PW-1:0] k);
    logic [WIDTH-1:0] c;
    int kk;
    kk = 0;
    kk[PW-1:0] = k;
    for (int i = 0; i < WIDTH; i++) begin
      c[i] = (kk <= WIDTH) ? (i < kk) : (i >= kk - WIDTH);
    end
    return c;
  endfunction

  function automatic logic in_range(input logic [PW-1:0] k);
    int kk;
    kk = 0;
    kk[PW-1:0] = k;
    return kk < NPH;
  endfunction

  logic             illegal;
  logic             load_ok;
  logic [WIDTH-1:0] load_code;
  logic [WIDTH-1:0] up_code;
  logic [WIDTH-1:0] down_code;
  logic [PW-1:0]    up_phase;
  logic [PW-1:0]    down_phase;

  // A state is legal only if phase is in range and count is exactly its code,
  // which also rules out every non-Johnson pattern of count.
  always_comb begin
    illegal    = !in_range(phase) || (count != code_of(phase));
    load_ok    = in_range(load_phase);
    load_code  = code_of(load_phase);
    up_code    = {count[WIDTH-2:0], ~count[WIDTH-1]};
    down_code  = {~count[0], count[WIDTH-1:1]};
    up_phase   = (phase == LAST_PHASE) ? '0 : phase + ONE_PHASE;
    down_phase = (phase == '0) ? LAST_PHASE : phase - ONE_PHASE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= code_of(RST_PHASE);
      phase     <= RST_PHASE;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
      state_err <= 1'b0;
    end else begin
      wrap      <= 1'b0;
      load_err  <= 1'b0;
      state_err <= 1'b0;
      if (illegal) begin
        count     <= '0;
        phase     <= '0;
        state_err <= 1'b1;
      end else if (load) begin
        if (load_ok) begin
          count <= load_code;
          phase <= load_phase;
        end else begin
          load_err <= 1'b1;
        end
      end else if (enable) begin
        if (up_down) begin
          count <= up_code;
          phase <= up_phase;
          wrap  <= (phase == LAST_PHASE);
        end else begin
          count <= down_code;
          phase <= down_phase;
          wrap  <= (phase == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_updown_counter_param.sv
// Self-checking bench for johnson_updown_counter_param: a directed vector table on a
// WIDTH=4 instance plus load-error, self-correction and random sweeps on other widths.
module tb_johnson_updown_counter_param;

  typedef struct {
    bit          rst;
    bit          en;
    bit          ud;
    bit          ld;
    int          lph;
    logic [31:0] cnt;
    int          ph;
    bit          w;
    string       name;
  } vec_t;

  typedef struct {
    int          d;
    logic [31:0] cnt;
    int          ph;
    bit          w;
    bit          le;
    bit          se;
    string       tag;
  } exp_t;

  localparam int NDUT = 5;
  localparam int WS[NDUT]  = '{4, 3, 2, 7, 16};
  localparam int RPS[NDUT] = '{0, 0, 2, 7, 16};
  localparam int PWS[NDUT] = '{3, 3, 2, 4, 5};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NDUT-1:0] en, ud, ld, wr, le, se;
  logic [2:0]  lp0, lp1;
  logic [1:0]  lp2;
  logic [3:0]  lp3;
  logic [4:0]  lp4;
  logic [3:0]  c0;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic [6:0]  c3;
  logic [15:0] c4;
  logic [2:0]  p0, p1;
  logic [1:0]  p2;
  logic [3:0]  p3;
  logic [4:0]  p4;
  logic [31:0] ca[NDUT];
  logic [31:0] pa[NDUT];

  int   lpv[NDUT];
  int   m_ph[NDUT];
  exp_t sb[$];
  vec_t tbl[19];
  vec_t nv;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  johnson_updown_counter_param #(.WIDTH(4), .RESET_PHASE(0)) u0 (
    .clk(clk), .rst(rst), .enable(en[0]), .up_down(ud[0]), .load(ld[0]), .load_phase(lp0),
    .count(c0), .phase(p0), .wrap(wr[0]), .load_err(le[0]), .state_err(se[0]));
  johnson_updown_counter_param #(.WIDTH(3), .RESET_PHASE(0)) u1 (
    .clk(clk), .rst(rst), .enable(en[1]), .up_down(ud[1]), .load(ld[1]), .load_phase(lp1),
    .count(c1), .phase(p1), .wrap(wr[1]), .load_err(le[1]), .state_err(se[1]));
  johnson_updown_counter_param #(.WIDTH(2), .RESET_PHASE(2)) u2 (
    .clk(clk), .rst(rst), .enable(en[2]), .up_down(ud[2]), .load(ld[2]), .load_phase(lp2),
    .count(c2), .phase(p2), .wrap(wr[2]), .load_err(le[2]), .state_err(se[2]));
  johnson_updown_counter_param #(.WIDTH(7), .RESET_PHASE(7)) u3 (
    .clk(clk), .rst(rst), .enable(en[3]), .up_down(ud[3]), .load(ld[3]), .load_phase(lp3),
    .count(c3), .phase(p3), .wrap(wr[3]), .load_err(le[3]), .state_err(se[3]));
  johnson_updown_counter_param #(.WIDTH(16), .RESET_PHASE(16)) u4 (
    .clk(clk), .rst(rst), .enable(en[4]), .up_down(ud[4]), .load(ld[4]), .load_phase(lp4),
    .count(c4), .phase(p4), .wrap(wr[4]), .load_err(le[4]), .state_err(se[4]));

  always_comb begin
    ca[0] = 32'(c0);  pa[0] = 32'(p0);
    ca[1] = 32'(c1);  pa[1] = 32'(p1);
    ca[2] = 32'(c2);  pa[2] = 32'(p2);
    ca[3] = 32'(c3);  pa[3] = 32'(p3);
    ca[4] = 32'(c4);  pa[4] = 32'(p4);
  end

  function automatic vec_t mk(input bit r, input bit e, input bit u, input bit l, input int lph,
                              input int cnt, input int ph, input bit w, input string name);
    vec_t v;
    v.rst = r;  v.en = e;  v.ud = u;  v.ld = l;  v.lph = lph;
    v.cnt = 32'(cnt);  v.ph = ph;  v.w = w;  v.name = name;
    return v;
  endfunction

  // Reference Johnson code built arithmetically from the phase-to-code mapping.
  function automatic logic [31:0] ref_code(input int w, input int k);
    logic [63:0] all_w;
    all_w = (64'd1 << w) - 64'd1;
    if (k <= w) return 32'((64'd1 << k) - 64'd1);
    return 32'(all_w ^ ((64'd1 << (k - w)) - 64'd1));
  endfunction

  task automatic set_lp(input int d, input int v);
    lpv[d] = v;
    case (d)
      0: lp0 = 3'(v);
      1: lp1 = 3'(v);
      2: lp2 = 2'(v);
      3: lp3 = 4'(v);
      default: lp4 = 5'(v);
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic idle_all();
    en = '0;
    ld = '0;
    ud = '0;
  endtask

  // Model every instance for one clock: push expectations, clock, then pop and compare.
  task automatic applyStimulus(input string tag, input bit tbl_on, input vec_t v);
    logic [31:0] prev[NDUT];
    bit          stepped[NDUT];
    exp_t        e;
    for (int d = 0; d < NDUT; d++) begin
      int n;
      int nph;
      bit ew;
      bit ele;
      n   = 2 * WS[d];
      nph = m_ph[d];
      ew  = 1'b0;
      ele = 1'b0;
      stepped[d] = 1'b0;
      if (rst) begin
        nph = RPS[d];
      end else if (ld[d]) begin
        if (lpv[d] < n) nph = lpv[d];
        else ele = 1'b1;
      end else if (en[d]) begin
        stepped[d] = 1'b1;
        if (ud[d]) begin
          ew  = (m_ph[d] == n - 1);
          nph = (m_ph[d] + 1) % n;
        end else begin
          ew  = (m_ph[d] == 0);
          nph = (m_ph[d] + n - 1) % n;
        end
      end
      m_ph[d] = nph;
      e.d   = d;
      e.cnt = ref_code(WS[d], nph);
      e.ph  = nph;
      e.w   = ew;
      e.le  = ele;
      e.se  = 1'b0;
      e.tag = $sformatf("%s/u%0d", tag, d);
      if (tbl_on && d == 0) begin
        e.cnt = v.cnt;
        e.ph  = v.ph;
        e.w   = v.w;
        e.le  = 1'b0;
      end
      sb.push_back(e);
      prev[d] = ca[d];
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, ".count"}, ca[e.d], e.cnt);
      checkOutput({e.tag, ".phase"}, pa[e.d], 32'(e.ph));
      checkOutput({e.tag, ".wrap"}, 32'(wr[e.d]), 32'(e.w));
      checkOutput({e.tag, ".load_err"}, 32'(le[e.d]), 32'(e.le));
      checkOutput({e.tag, ".state_err"}, 32'(se[e.d]), 32'(e.se));
    end
    for (int d = 0; d < NDUT; d++) begin
      if (stepped[d] && !tbl_on)
        checkOutput($sformatf("%s/u%0d.one_bit_toggle", tag, d),
                    32'($countones(ca[d] ^ prev[d])), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1, 1, 1, 1, 5, 'b0000, 0, 0, "reset_a");
    tbl[1]  = mk(1, 1, 1, 1, 5, 'b0000, 0, 0, "reset_b");
    tbl[2]  = mk(0, 1, 1, 0, 0, 'b0001, 1, 0, "up_1");
    tbl[3]  = mk(0, 1, 1, 0, 0, 'b0011, 2, 0, "up_2");
    tbl[4]  = mk(0, 1, 1, 0, 0, 'b0111, 3, 0, "up_3");
    tbl[5]  = mk(0, 1, 1, 0, 0, 'b1111, 4, 0, "up_4");
    tbl[6]  = mk(0, 1, 1, 0, 0, 'b1110, 5, 0, "up_5");
    tbl[7]  = mk(0, 1, 1, 0, 0, 'b1100, 6, 0, "up_6");
    tbl[8]  = mk(0, 1, 1, 0, 0, 'b1000, 7, 0, "up_7");
    tbl[9]  = mk(0, 1, 1, 0, 0, 'b0000, 0, 1, "up_wrap");
    tbl[10] = mk(0, 1, 1, 0, 0, 'b0001, 1, 0, "up_9");
    tbl[11] = mk(0, 1, 0, 0, 0, 'b0000, 0, 0, "down_to_0");
    tbl[12] = mk(0, 1, 0, 0, 0, 'b1000, 7, 1, "down_wrap");
    tbl[13] = mk(0, 1, 1, 0, 0, 'b0000, 0, 1, "dir_change_wrap");
    tbl[14] = mk(0, 1, 1, 1, 5, 'b1110, 5, 0, "load_5");
    tbl[15] = mk(0, 0, 1, 0, 0, 'b1110, 5, 0, "hold");
    tbl[16] = mk(0, 0, 0, 1, 2, 'b0011, 2, 0, "load_2");
    tbl[17] = mk(1, 1, 1, 0, 0, 'b0000, 0, 0, "mid_reset");
    tbl[18] = mk(0, 1, 1, 0, 0, 'b0001, 1, 0, "resume");

    idle_all();
    for (int d = 0; d < NDUT; d++) begin
      set_lp(d, 0);
      m_ph[d] = 0;
    end

    for (int i = 0; i < 19; i++) begin
      idle_all();
      rst   = tbl[i].rst;
      en[0] = tbl[i].en;
      ud[0] = tbl[i].ud;
      ld[0] = tbl[i].ld;
      set_lp(0, tbl[i].lph);
      applyStimulus(tbl[i].name, 1'b1, tbl[i]);
    end

    // Reset phase equal to WIDTH gives an all-ones code.
    checkOutput("u2.reset_all_ones", ca[2], 32'h3);
    checkOutput("u3.reset_all_ones", ca[3], 32'h7f);
    checkOutput("u4.reset_all_ones", ca[4], 32'hffff);
    checkOutput("u4.reset_phase", pa[4], 32'd16);

    // Self-correction: dut0 sits at phase 1; corrupt its code across one edge.
    rst = 1'b0;
    idle_all();
    en[0] = 1'b1;
    ud[0] = 1'b1;
    force u0.count = 4'b0101;
    @(posedge clk);
    #1;
    release u0.count;
    en[0] = 1'b0;
    checkOutput("corr.state_err", 32'(se[0]), 32'd1);
    checkOutput("corr.phase", pa[0], 32'd0);
    checkOutput("corr.wrap", 32'(wr[0]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("corr.count_zero", ca[0], 32'd0);
    checkOutput("corr.phase_zero", pa[0], 32'd0);
    @(posedge clk);
    #1;
    checkOutput("corr.state_err_cleared", 32'(se[0]), 32'd0);
    checkOutput("corr.count_held", ca[0], 32'd0);
    m_ph[0] = 0;
    en[0] = 1'b1;
    ud[0] = 1'b1;
    applyStimulus("corr_resume", 1'b0, nv);
    checkOutput("corr.resume_count", ca[0], 32'b0001);

    // WIDTH=3: load_phase 7 is out of range and must be rejected.
    idle_all();
    ld[1] = 1'b1;
    set_lp(1, 4);
    applyStimulus("w3_load4", 1'b0, nv);
    en[1] = 1'b1;
    set_lp(1, 7);
    applyStimulus("w3_load7", 1'b0, nv);
    checkOutput("w3.load_err", 32'(le[1]), 32'd1);
    checkOutput("w3.count_held", ca[1], 32'b110);
    checkOutput("w3.phase_held", pa[1], 32'd4);
    idle_all();
    applyStimulus("w3_idle", 1'b0, nv);
    checkOutput("w3.load_err_pulse", 32'(le[1]), 32'd0);

    // Random sweep on every instance against the reference model.
    for (int c = 0; c < 64; c++) begin
      rst = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
        en[d] = ($urandom_range(3) != 0);
        ud[d] = ($urandom_range(1) != 0);
        ld[d] = ($urandom_range(7) == 0);
        set_lp(d, int'($urandom_range((1 << PWS[d]) - 1)));
      end
      applyStimulus($sformatf("rand%0d", c), 1'b0, nv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
